// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-channel request/idle-timeout clock gating with glitch-free latch-and-AND cells
module clk_gate_ctrl #(
  parameter int NUM_CH = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  localparam int CNT_W = $clog2(IDLE_CYCLES + WAKE_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_en_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] busy_i,
  input  logic [NUM_CH-1:0] force_on_i,
  output logic [NUM_CH-1:0] gated_clk_o,
  output logic [NUM_CH-1:0] ack_o,
  output logic [NUM_CH-1:0] clk_on_o
);
  typedef enum logic [1:0] {OFF, WAKE, ON} state_t;
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES > 0 ? WAKE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, on_q, lat_q, act;
    assign act = req_i[i] | busy_i[i] | force_on_i[i];
    // next state: wake countdown, then idle timeout that any activity restarts
    always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      case (state_q)
        OFF: if (act) begin
          state_d = WAKE_CYCLES > 0 ? WAKE : ON;
          cnt_d = '0;
        end
        WAKE: begin
          state_d = cnt_q == WAKE_LAST ? ON : WAKE;
          cnt_d = cnt_q == WAKE_LAST ? '0 : cnt_q + 1'b1;
        end
        ON: begin
          state_d = !act && cnt_q == IDLE_LAST ? OFF : ON;
          cnt_d = act || cnt_q == IDLE_LAST ? '0 : cnt_q + 1'b1;
        end
        default: begin
          state_d = OFF;
          cnt_d = '0;
        end
      endcase
    end
    // state, counter and registered status; on_q doubles as the gate enable flop
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= OFF;
        cnt_q <= '0;
        ack_q <= 1'b0;
        on_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        ack_q <= state_d == ON;
        on_q <= state_d != OFF;
      end
    end
    // enable latch open only while clk is low so the AND never sees a mid-high change
    always_latch begin
      if (rst_i) lat_q <= 1'b0;
      else if (!clk_i) lat_q <= on_q;
    end
    assign gated_clk_o[i] = (clk_i & lat_q) | (clk_i & test_en_i);
    assign ack_o[i] = ack_q;
    assign clk_on_o[i] = on_q;
  end
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed checks of wake, idle timeout, override, bypass and glitch-free gating
module tb_clk_gate_ctrl;
  logic clk = 1'b0, rst = 1'b1, test_en = 1'b0;
  logic [3:0] req = '0, busy = '0, force_on = '0, gc, ack, con;
  logic [3:0] req0 = '0, gc0, ack0, con0;
  int n_chk = 0, n_fail = 0;
  int rises [4] = '{0, 0, 0, 0};
  int npulse = 0, runt = 0;
  bit mon = 1'b0;
  time rt = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl dut (.clk_i(clk), .rst_i(rst), .test_en_i(test_en), .req_i(req), .busy_i(busy),
    .force_on_i(force_on), .gated_clk_o(gc), .ack_o(ack), .clk_on_o(con));

  clk_gate_ctrl #(.WAKE_CYCLES(0)) dut0 (.clk_i(clk), .rst_i(rst), .test_en_i(1'b0), .req_i(req0),
    .busy_i(4'h0), .force_on_i(4'h0), .gated_clk_o(gc0), .ack_o(ack0), .clk_on_o(con0));

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++) if (gc[k]) rises[k]++;
  end

  always @(posedge gc0[0]) rt = $time;
  always @(negedge gc0[0]) if (mon) begin
    npulse++;
    if (($time - rt) != 5 || (rt % 10) != 5) runt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int base [4];
    tick();
    req = 4'hF;
    tick(3);
    n_chk++; if (ack !== 4'hF) begin n_fail++; $display("FAIL reset_pre ack=%h exp=f", ack); end
    rst = 1'b1;
    #1;
    n_chk++; if (gc !== 4'h0) begin n_fail++; $display("FAIL reset_gc gc=%h exp=0", gc); end
    n_chk++; if (ack !== 4'h0 || con !== 4'h0) begin n_fail++; $display("FAIL reset_out ack=%h con=%h exp=0", ack, con); end
    req = 4'h0;
    tick(2);
    rst = 1'b0;
    base = rises;
    tick(20);
    n_chk++; if (rises != base) begin n_fail++; $display("FAIL reset_idle rises changed exp=none"); end
    n_chk++; if (ack !== 4'h0 || con !== 4'h0) begin n_fail++; $display("FAIL reset_idle_out ack=%h con=%h exp=0", ack, con); end
  endtask

  task automatic test_wake;
    int base [4];
    base = rises;
    req[0] = 1'b1;
    tick();
    n_chk++; if (con !== 4'h1 || ack !== 4'h0) begin n_fail++; $display("FAIL wake_e0 con=%h ack=%h exp=1/0", con, ack); end
    n_chk++; if (gc[0] !== 1'b0) begin n_fail++; $display("FAIL wake_gc_e0 gc=%b exp=0", gc[0]); end
    tick();
    n_chk++; if (gc[0] !== 1'b1 || ack[0] !== 1'b0) begin n_fail++; $display("FAIL wake_e1 gc=%b ack=%b exp=1/0", gc[0], ack[0]); end
    tick();
    n_chk++; if (ack !== 4'h1) begin n_fail++; $display("FAIL wake_ack ack=%h exp=1", ack); end
    n_chk++; if (rises[1] != base[1] || rises[2] != base[2] || rises[3] != base[3] || con[3:1] !== 3'b0)
      begin n_fail++; $display("FAIL wake_quiet con=%h exp=1", con); end
  endtask

  task automatic test_idle;
    req[0] = 1'b0;
    tick(7);
    n_chk++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL idle7 ack=%b exp=1", ack[0]); end
    tick();
    n_chk++; if (ack[0] !== 1'b0 || con[0] !== 1'b0) begin n_fail++; $display("FAIL idle8 ack=%b con=%b exp=0", ack[0], con[0]); end
    n_chk++; if (gc[0] !== 1'b1) begin n_fail++; $display("FAIL idle_last_pulse gc=%b exp=1", gc[0]); end
    tick();
    n_chk++; if (gc[0] !== 1'b0) begin n_fail++; $display("FAIL idle_stopped gc=%b exp=0", gc[0]); end
    req[0] = 1'b1;
    tick(3);
    n_chk++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL rewake ack=%b exp=1", ack[0]); end
    req[0] = 1'b0;
    tick(4);
    busy[0] = 1'b1;
    tick();
    busy[0] = 1'b0;
    tick(7);
    n_chk++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL busy_restart7 ack=%b exp=1", ack[0]); end
    tick();
    n_chk++; if (ack[0] !== 1'b0 || con[0] !== 1'b0) begin n_fail++; $display("FAIL busy_restart8 ack=%b con=%b exp=0", ack[0], con[0]); end
  endtask

  task automatic test_glitch;
    int o [6] = '{1, 3, 6, 8, 9, 4};
    int d [6] = '{2, 15, 23, 6, 33, 4};
    mon = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #(o[n]) req0[0] = 1'b1;
      #(d[n]) req0[0] = 1'b0;
      repeat (12) @(posedge clk);
    end
    tick();
    mon = 1'b0;
    n_chk++; if (npulse == 0) begin n_fail++; $display("FAIL glitch_pulses got=%0d exp>0", npulse); end
    n_chk++; if (runt != 0) begin n_fail++; $display("FAIL glitch_runt got=%0d exp=0", runt); end
    n_chk++; if (con0[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_off con=%b exp=0", con0[0]); end
  endtask

  task automatic test_parallel;
    int bad = 0;
    force_on[3] = 1'b1;
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    n_chk++; if (con[1] !== 1'b1 || ack[1] !== 1'b0) begin n_fail++; $display("FAIL par_wake con=%b ack=%b exp=1/0", con[1], ack[1]); end
    tick(2);
    n_chk++; if (ack[1] !== 1'b1 || ack[3] !== 1'b1) begin n_fail++; $display("FAIL par_on ack=%h exp=a", ack); end
    tick(7);
    n_chk++; if (ack[1] !== 1'b1) begin n_fail++; $display("FAIL par_idle7 ack=%b exp=1", ack[1]); end
    tick();
    n_chk++; if (ack[1] !== 1'b0 || con[1] !== 1'b0) begin n_fail++; $display("FAIL par_idle8 ack=%b con=%b exp=0", ack[1], con[1]); end
    for (int n = 0; n < 39; n++) begin
      tick();
      if (ack[3] !== 1'b1 || gc[3] !== 1'b1) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL par_force bad=%0d exp=0", bad); end
    force_on[3] = 1'b0;
    tick(9);
    n_chk++; if (ack !== 4'h0) begin n_fail++; $display("FAIL par_release ack=%h exp=0", ack); end
  endtask

  task automatic test_bypass;
    int bad = 0;
    test_en = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (gc !== 4'hF || ack !== 4'h0) bad++;
      @(negedge clk);
      #1;
      if (gc !== 4'h0) bad++;
    end
    test_en = 1'b0;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL bypass bad=%0d exp=0", bad); end
    tick();
    n_chk++; if (gc !== 4'h0) begin n_fail++; $display("FAIL bypass_off gc=%h exp=0", gc); end
  endtask

  initial begin
    #12 rst = 1'b0;
    test_reset();
    test_wake();
    test_idle();
    test_glitch();
    test_parallel();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Multi-channel clock-gating controller. Generates NUM_CH glitch-free gated clocks from one source clock.
- Each channel is enabled on demand through a request/acknowledge handshake. It is gated off automatically after a programmable run of idle cycles.
- Sits at the clock-domain boundary, feeding gated clocks to ALU, register-file and similar consumers.
- Replaces the single fixed-enable latch-and-AND gate.

Parameters:
- NUM_CH, 4, number of independent gated-clock channels (≥1).
- IDLE_CYCLES, 8, consecutive idle cycles in ON before a channel gates off (≥1).
- WAKE_CYCLES, 2, cycles the clock runs in WAKE before ACK asserts (≥0).
- CNT_W, $clog2(IDLE_CYCLES+WAKE_CYCLES+1), internal counter width (derived, not overridden).

Ports:
- CLK  input  1  source clock.
- RST  input  1  asynchronous reset, active-high.
- TEST_EN  input  1  scan/test bypass: all GATED_CLK follow CLK when 1.
- REQ  input  NUM_CH  per-channel clock request (level).
- BUSY  input  NUM_CH  per-channel consumer-activity flag; holds the clock on while high.
- FORCE_ON  input  NUM_CH  per-channel software override; the clock stays running.
- GATED_CLK  output  NUM_CH  gated clocks.
- ACK  output  NUM_CH  registered; the channel clock is stable and usable.
- CLK_ON  output  NUM_CH  registered; the channel enable is asserted (WAKE or ON).

Behaviour:
- Each channel has an independent FSM with states OFF, WAKE and ON, plus one CNT_W-bit counter. All state is updated on the posedge of CLK.
- Reset (RST=1, asynchronous):
  - All FSMs go to OFF and counters clear.
  - The enable flop and the gating latch clear.
  - ACK=0, CLK_ON=0, GATED_CLK=0 (unless TEST_EN=1).
  - Reset mid-WAKE or mid-ON drops the channel immediately; no handshake completes.
- act[i] = REQ[i] | BUSY[i] | FORCE_ON[i].
- OFF: EN=0, ACK=0.
  - If act[i] at an edge and WAKE_CYCLES>0: go to WAKE and load counter=0.
  - If act[i] at an edge and WAKE_CYCLES=0: go straight to ON.
- WAKE: EN=1, ACK=0.
  - Counter increments each edge.
  - When counter==WAKE_CYCLES-1, go to ON and clear the counter.
  - REQ deasserting during WAKE does not abort. The channel completes to ON and then idles out.
- ON: EN=1, ACK=1.
  - If act[i]: counter clears.
  - Otherwise the counter increments.
  - When counter==IDLE_CYCLES-1 with act[i]=0, go to OFF and clear the counter. The channel therefore gates off after exactly IDLE_CYCLES consecutive idle samples.
- CLK_ON[i] = registered (state≠OFF). ACK[i] = registered (state==ON). Both update at the same edge as the state.
- Gating cell, per channel:
  - The EN flop output feeds a latch that is transparent while CLK=0 and has async clear on RST.
  - GATED_CLK[i] = (CLK & latch[i]) | (CLK & TEST_EN).
  - No partial high pulses.
- Timing, with REQ first sampled high at edge 0:
  - EN=1 after edge 0.
  - The first GATED_CLK high phase starts at edge 1.
  - ACK=1 after edge WAKE_CYCLES.
  - Final GATED_CLK high phase is the one beginning at the edge that moves the state to OFF.
- Channels are fully independent. Simultaneous requests on all channels are legal and each wakes in parallel.
- TEST_EN affects only the GATED_CLK outputs. The FSMs, ACK and CLK_ON operate normally.

Test Plan:
- Reset: RST=1 mid-cycle with CLK toggling → GATED_CLK=0, ACK=0 and CLK_ON=0 immediately; after release, an idle bench produces no gated pulses for 20 cycles.
- Wake handshake: defaults, REQ[0]=1 at edge 0 → CLK_ON[0]=1 after edge 0, first GATED_CLK[0] rise at edge 1, ACK[0]=1 after edge 2; channels 1–3 stay silent.
- Idle timeout: after ACK, drop REQ[0]/BUSY[0] → exactly 8 idle edges, then ACK=0 and CLK_ON=0; a BUSY pulse at idle cycle 5 restarts the count (gate-off 8 cycles after the pulse).
- Glitch check: toggle REQ asynchronously around both CLK phases with WAKE_CYCLES=0 → every GATED_CLK high pulse is a full CLK high phase (no runt pulses).
- Parallel and override: FORCE_ON[3]=1 held for 50 cycles while REQ[1] pulses once → ch3 never gates off; ch1 completes wake, runs 8 idle cycles, then stops; REQ dropped during ch1 WAKE still reaches ON.
- Test bypass: TEST_EN=1 with all channels OFF → every GATED_CLK equals CLK, ACK stays 0.
